reset_sequencer: RTL and testbench

- Controls the system clock/reset resource: watches PLL lock and the user run/reset button, then releases per-domain synchronous resets in a fixed staggered order.
- Sits directly after the PLL/BUFG clock generator, in the generated clock domain.
- Feeds the video, UART/USB and terminal-core reset inputs.
- Re-asserts all resets on lock loss or button press, and counts lock-loss events for debug.

---
 rtl/reset_sequencer_pkg.sv | 20 ++
 rtl/reset_sequencer_sync_debounce.sv | 61 ++++++
 rtl/reset_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_reset_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reset_sequencer_pkg.sv
// Shared types and constants for the reset sequencer: FSM state encoding,
// lock-loss counter width, and the counter sizing rule used by every timer.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    COUNT   = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } seq_state_e;

  localparam int                     LOCK_LOSS_W   = 8;
  localparam logic [LOCK_LOSS_W-1:0] LOCK_LOSS_MAX = '1;

  // Width of a counter that must reach the value n (compared by equality).
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/reset_sequencer_sync_debounce.sv
// Two-flop synchroniser for an asynchronous input, optionally followed by a
// stability filter. With DEPTH = 0 the synchronised value is passed straight
// through; otherwise the output only follows the synchronised input after it
// has differed from the current output for DEPTH consecutive cycles.
module reset_sequencer_sync_debounce
  import reset_sequencer_pkg::*;
#(
  parameter int DEPTH = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  logic meta_q;
  logic sync_q;

  // Metastability-hardening double flop; both stages clear to 0 in reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
    end
  end

  generate
    if (DEPTH == 0) begin : g_no_filter
      assign dout = sync_q;
    end else begin : g_filter
      localparam int            CW   = cnt_width(DEPTH);
      localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

      logic [CW-1:0] cnt_q;
      logic          stable_q;

      // Count consecutive disagreeing cycles; any agreement restarts the count.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt_q    <= '0;
          stable_q <= 1'b0;
        end else if (sync_q != stable_q) begin
          if (cnt_q == LAST) begin
            stable_q <= sync_q;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end else begin
          cnt_q <= '0;
        end
      end

      assign dout = stable_q;
    end
  endgenerate

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer for the generated clock domain. Waits for PLL lock and a
// debounced run button, holds all domain resets for a minimum time, then
// releases them one at a time in index order. Any loss of lock or button
// drops everything back into reset at once; lock losses after release has
// started are counted (saturating) for debug.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   HOLD    | all resets asserted, waiting for lock and button to be good
//   COUNT   | lock and button good, timing the minimum hold period
//   RELEASE | domain 0.. released, stepping to the next domain each stagger
//   RUN     | every domain out of reset
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int NUM_DOMAINS     = 3,
  parameter int HOLD_CYCLES     = 32,
  parameter int STAGGER_CYCLES  = 16,
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   pll_locked,
  input  logic                   button,
  input  logic                   clr_count,
  output logic [NUM_DOMAINS-1:0] domain_reset,
  output logic                   all_released,
  output logic [LOCK_LOSS_W-1:0] lock_loss_count
);

  localparam int HOLD_W = cnt_width(HOLD_CYCLES);
  localparam int STG_W  = cnt_width(STAGGER_CYCLES);
  localparam int IDX_W  = cnt_width(NUM_DOMAINS);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [STG_W-1:0]  STG_LAST  = STG_W'(STAGGER_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);

  logic lock_s;
  logic button_db;
  logic ok;
  logic lock_event;

  seq_state_e             state_q,  state_d;
  logic [HOLD_W-1:0]      hold_q,   hold_d;
  logic [STG_W-1:0]       stg_q,    stg_d;
  logic [IDX_W-1:0]       idx_q,    idx_d;
  logic [NUM_DOMAINS-1:0] dr_q,     dr_d;
  logic                   ar_q,     ar_d;
  logic [LOCK_LOSS_W-1:0] llc_q;

  // PLL lock is level-only; no filtering, just synchronised.
  reset_sequencer_sync_debounce #(
    .DEPTH (0)
  ) u_lock_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (pll_locked),
    .dout    (lock_s)
  );

  reset_sequencer_sync_debounce #(
    .DEPTH (DEBOUNCE_CYCLES)
  ) u_button_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (button),
    .dout    (button_db)
  );

  assign ok         = lock_s & button_db;
  assign lock_event = ((state_q == RELEASE) || (state_q == RUN)) && !lock_s;

  // Next-state and next-output decode; loss of ok always wins over release.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    stg_d   = stg_q;
    idx_d   = idx_q;
    dr_d    = dr_q;
    ar_d    = ar_q;

    case (state_q)
      HOLD: begin
        dr_d   = '1;
        ar_d   = 1'b0;
        hold_d = '0;
        stg_d  = '0;
        idx_d  = '0;
        if (ok) begin
          state_d = COUNT;
        end
      end

      COUNT: begin
        if (!ok) begin
          state_d = HOLD;
          hold_d  = '0;
        end else if (hold_q == HOLD_LAST) begin
          hold_d  = '0;
          stg_d   = '0;
          dr_d[0] = 1'b0;
          if (NUM_DOMAINS == 1) begin
            state_d = RUN;
            ar_d    = 1'b1;
          end else begin
            state_d = RELEASE;
            idx_d   = IDX_W'(1);
          end
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end

      RELEASE: begin
        if (!ok) begin
          state_d = HOLD;
          dr_d    = '1;
          ar_d    = 1'b0;
          stg_d   = '0;
          idx_d   = '0;
        end else if (stg_q == STG_LAST) begin
          stg_d = '0;
          for (int i = 0; i < NUM_DOMAINS; i++) begin
            if (IDX_W'(i) == idx_q) begin
              dr_d[i] = 1'b0;
            end
          end
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) begin
            state_d = RUN;
            ar_d    = 1'b1;
          end
        end else begin
          stg_d = stg_q + STG_W'(1);
        end
      end

      RUN: begin
        if (!ok) begin
          state_d = HOLD;
          dr_d    = '1;
          ar_d    = 1'b0;
          stg_d   = '0;
          idx_d   = '0;
        end
      end

      default: begin
        state_d = HOLD;
        dr_d    = '1;
        ar_d    = 1'b0;
      end
    endcase
  end

  // State, timers and the registered reset outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= HOLD;
      hold_q  <= '0;
      stg_q   <= '0;
      idx_q   <= '0;
      dr_q    <= '1;
      ar_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      stg_q   <= stg_d;
      idx_q   <= idx_d;
      dr_q    <= dr_d;
      ar_q    <= ar_d;
    end
  end

  // Saturating lock-loss counter; a clear in the same cycle as a loss wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      llc_q <= '0;
    end else if (clr_count) begin
      llc_q <= '0;
    end else if (lock_event && (llc_q != LOCK_LOSS_MAX)) begin
      llc_q <= llc_q + LOCK_LOSS_W'(1);
    end
  end

  assign domain_reset    = dr_q;
  assign all_released    = ar_q;
  assign lock_loss_count = llc_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer with short timing parameters.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       pll_locked;
  logic       button;
  logic       clr_count;
  logic [2:0] domain_reset;
  logic       all_released;
  logic [7:0] lock_loss_count;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int         cyc;
    logic       pll;
    logic       btn;
    logic [2:0] dr;
    logic       ar;
  } vec_t;

  typedef struct packed {
    logic [2:0] dr;
    logic       ar;
    logic [7:0] llc;
  } exp_t;

  vec_t vecs [9];
  exp_t exp_q [$];

  reset_sequencer #(
    .NUM_DOMAINS     (3),
    .HOLD_CYCLES     (4),
    .STAGGER_CYCLES  (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .pll_locked      (pll_locked),
    .button          (button),
    .clr_count       (clr_count),
    .domain_reset    (domain_reset),
    .all_released    (all_released),
    .lock_loss_count (lock_loss_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, got, expv);
  endtask

  task automatic wait_dr(input string name, input logic [2:0] v, input int limit,
                         output int n, output bit ok);
    n = 0;
    while (domain_reset !== v && n < limit) begin
      tick();
      n++;
    end
    ok = (domain_reset === v);
    if (!ok) begin
      n_checks++;
      $display("FAIL %s: timeout, domain_reset=%b required %b", name, domain_reset, v);
    end
  endtask

  // Wait for the first release, optionally check its latency, then the stagger.
  task automatic release_seq(input string name, input int exact);
    int n;
    bit ok;
    wait_dr({name, "_first"}, 3'b110, 60, n, ok);
    if (ok) begin
      if (exact > 0) check({name, "_latency"}, n, exact);
      check({name, "_ar0"}, all_released, 1'b0);
      tick(); check({name, "_d0b"}, domain_reset, 3'b110);
      tick(); check({name, "_d1a"}, domain_reset, 3'b100);
      tick(); check({name, "_d1b"}, domain_reset, 3'b100);
      check({name, "_ar1"}, all_released, 1'b0);
      tick(); check({name, "_d2"}, domain_reset, 3'b000);
      check({name, "_allrel"}, all_released, 1'b1);
    end
  endtask

  // One-cycle lock drop; resets must all be asserted within three edges.
  task automatic lock_pulse(input string name);
    int n;
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    n = 1;
    while (domain_reset !== 3'b111 && n < 3) begin
      tick();
      n++;
    end
    check({name, "_assert"}, domain_reset, 3'b111);
    check({name, "_ar"}, all_released, 1'b0);
  endtask

  initial begin
    int  cur;
    int  n;
    bit  ok;
    bit  bad;
    exp_t e;

    vecs[0] = '{1,  1'b1, 1'b1, 3'b111, 1'b0};
    vecs[1] = '{6,  1'b1, 1'b1, 3'b111, 1'b0};
    vecs[2] = '{10, 1'b1, 1'b1, 3'b111, 1'b0};
    vecs[3] = '{11, 1'b1, 1'b1, 3'b110, 1'b0};
    vecs[4] = '{12, 1'b1, 1'b1, 3'b110, 1'b0};
    vecs[5] = '{13, 1'b1, 1'b1, 3'b100, 1'b0};
    vecs[6] = '{14, 1'b1, 1'b1, 3'b100, 1'b0};
    vecs[7] = '{15, 1'b1, 1'b1, 3'b000, 1'b1};
    vecs[8] = '{20, 1'b1, 1'b1, 3'b000, 1'b1};

    reset_n    = 1'b0;
    pll_locked = 1'b1;
    button     = 1'b1;
    clr_count  = 1'b0;

    // Reset state
    tick();
    check("rst_dr", domain_reset, 3'b111);
    check("rst_ar", all_released, 1'b0);
    check("rst_llc", lock_loss_count, 8'd0);
    repeat (4) tick();
    reset_n = 1'b1;

    // Power-up release, table driven: sync 2 + debounce 4 + fsm 1 + hold 4
    cur = 0;
    for (int i = 0; i < 9; i++) begin
      pll_locked = vecs[i].pll;
      button     = vecs[i].btn;
      while (cur < vecs[i].cyc) begin
        tick();
        cur++;
      end
      exp_q.push_back('{vecs[i].dr, vecs[i].ar, 8'd0});
      e = exp_q.pop_front();
      check($sformatf("pwr_dr_c%0d", vecs[i].cyc), domain_reset, e.dr);
      check($sformatf("pwr_ar_c%0d", vecs[i].cyc), all_released, e.ar);
      check($sformatf("pwr_llc_c%0d", vecs[i].cyc), lock_loss_count, e.llc);
    end

    // Lock drop in RUN
    lock_pulse("run_drop");
    check("run_drop_llc", lock_loss_count, 8'd1);
    release_seq("run_drop_rel", 5);

    // Button bounce in RUN must not reset
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      button = ((i / 2) % 2) == 1;
      tick();
      if (domain_reset !== 3'b000) bad = 1'b1;
    end
    button = 1'b1;
    repeat (4) begin
      tick();
      if (domain_reset !== 3'b000) bad = 1'b1;
    end
    check("bounce_no_reset", bad, 1'b0);

    // Button held low six cycles: 2 sync + 4 debounce + 1 fsm edges
    button = 1'b0;
    n = 0;
    while (domain_reset !== 3'b111 && n < 12) begin
      tick();
      n++;
      if (n == 6) button = 1'b1;
    end
    button = 1'b1;
    check("btn_hold_latency", n, 7);
    check("btn_hold_llc", lock_loss_count, 8'd1);

    // Lock loss mid-RELEASE
    wait_dr("mid_rel_wait", 3'b110, 60, n, ok);
    lock_pulse("mid_rel_drop");
    check("mid_rel_llc", lock_loss_count, 8'd2);
    release_seq("mid_rel_rel", 5);

    // Clear, saturation, clear coincident with a counted loss
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    check("clr_llc", lock_loss_count, 8'd0);
    for (int i = 0; i < 260; i++) begin
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      wait_dr("sat_assert", 3'b111, 3, n, ok);
      if (!ok) break;
      wait_dr("sat_release", 3'b110, 40, n, ok);
      if (!ok) break;
    end
    check("sat_llc", lock_loss_count, 8'd255);
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    tick();
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    check("clr_win_dr", domain_reset, 3'b111);
    check("clr_win_llc", lock_loss_count, 8'd0);

    // One more counted loss, then back to RUN
    wait_dr("post_clr_wait", 3'b110, 40, n, ok);
    lock_pulse("post_clr_drop");
    check("post_clr_llc", lock_loss_count, 8'd1);
    wait_dr("post_clr_run", 3'b000, 40, n, ok);
    check("post_clr_ar", all_released, 1'b1);

    // Async reset mid-RUN, observed before any clock edge
    #2;
    reset_n = 1'b0;
    #1;
    check("async_dr", domain_reset, 3'b111);
    check("async_ar", all_released, 1'b0);
    check("async_llc", lock_loss_count, 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
